cache_wb_buffer: RTL and testbench
==================================

CACHE_WB_BUFFER -- requirements
Module: cache_wb_buffer

Interface
REQ-001 Parameter: DEPTH, 2, number of write-back entries (legal values 1..4).
REQ-002 Ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Ports: rst_n  in  1  synchronous, active-low reset.
REQ-004 Ports: cache_req  in  mem_req_type (162)  line request from cache controller: addr, data, rw (1=write-back, 0=refill read), valid.
REQ-005 Ports: cache_rsp  out  mem_data_type (129)  to cache controller: ready pulse, with data for reads.
REQ-006 Ports: mem_req  out  mem_req_type (162)  to memory.
REQ-007 Ports: mem_rsp  in  mem_data_type (129)  from memory: ready pulse, with data for reads.
REQ-008 Ports: full  out  1  high when all DEPTH entries are occupied.

Function
REQ-009 Line match SHALL compare addr[31:4] only; addr[3:0] SHALL be ignored.
REQ-010 cache_req SHALL be sampled only on an edge where cache_req.valid=1, cache_rsp.ready=0 and no accepted read is outstanding; the block SHALL ignore it at all other edges.
REQ-011 An accepted write SHALL take the oldest matching entry that is not in flight and overwrite its data (coalesce), else take a free entry; with no free entry and no coalesce target it SHALL stay unaccepted until one frees.
REQ-012 An accepted write SHALL assert cache_rsp.ready for exactly 1 cycle on the cycle after acceptance, with cache_rsp.data=0.
REQ-013 An accepted read matching a buffered entry (newest if several, in-flight included) SHALL return that entry's data on cache_rsp the next cycle with ready=1, and SHALL NOT issue to memory.
REQ-014 An accepted read with no match SHALL become the pending read and SHALL NOT be held in a buffer entry.
REQ-015 Memory-side FSM states: IDLE, RD_WAIT, WR_WAIT.
REQ-016 IDLE SHALL issue the pending read first (-> RD_WAIT); otherwise the oldest non-empty entry (-> WR_WAIT); otherwise stay in IDLE.
REQ-017 mem_req SHALL be registered and held constant (addr line-aligned, [3:0]=0) from issue until the edge where mem_rsp.ready=1, then go to 0 and the FSM SHALL return to IDLE.
REQ-018 On RD_WAIT completion, cache_rsp SHALL be ready=1 with data=mem_rsp.data for 1 cycle, the cycle after mem_rsp.ready.
REQ-019 On WR_WAIT completion, the head entry SHALL be freed; entries SHALL drain in allocation order.
REQ-020 full SHALL be combinational from the entry valid bits.
REQ-021 An entry freeing and an allocation on the same edge SHALL both take effect; a full buffer SHALL then accept the write.
REQ-022 mem_rsp.ready seen while in IDLE SHALL be ignored.
REQ-023 cache_rsp.ready SHALL never stay high 2 consecutive cycles.

Reset
REQ-024 While rst_n=0 at an edge, all entries SHALL become invalid, the pending read SHALL be dropped and the FSM SHALL go to IDLE.
REQ-025 While rst_n=0 at an edge, mem_req and cache_rsp SHALL become all zeros and full SHALL read 0.
REQ-026 A reset during RD_WAIT or WR_WAIT SHALL abandon the transaction with no response, and the memory model SHALL tolerate this.

Structure
REQ-027 mem_req_type and mem_data_type SHALL come from package cache_def_pipe_data.
REQ-028 wb_entry_type {valid, line_addr[31:4], data[127:0]} and WB_DEPTH=2 SHALL be added to that package.
REQ-029 The block SHALL be a single module with the entry array inline and no sub-module.

Verification
REQ-030 Write 0x0000_1230 with data D1 -> ready 1 cycle after acceptance; mem_req write to 0x0000_1230 with D1 issued the next cycle; entry freed on mem ready.
REQ-031 Write 0x2000 with data D2, then read 0x2008 before the drain completes -> read returns D2 the next cycle; no memory read issued.
REQ-032 With DEPTH=2 and memory stalled, write 0x100, then 0x200, then 0x300 -> full=1 and the third write waits; it is accepted on the edge the 0x100 drain completes and ready pulses the cycle after.
REQ-033 Read 0x4000 (miss) while 0x100 is buffered -> the read is issued before the write; cache_rsp.data equals the memory data 1 cycle after mem_rsp.ready.
REQ-034 Write 0x500 with data A, then 0x500 with data B while not in flight -> a single entry holding B and a single memory write.
REQ-035 rst_n=0 during WR_WAIT -> the next cycle mem_req=0, cache_rsp=0, full=0; after release, a read of that line goes to memory.

Source files
------------

// File: rtl/cache_wb_buffer_pkg.sv
// Shared memory-interface types and write-back buffer definitions for the
// cache-to-memory path.
package cache_def_pipe_data;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  localparam int WB_DEPTH = 2;

  typedef struct packed {
    logic         valid;
    logic [31:4]  line_addr;
    logic [127:0] data;
  } wb_entry_type;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } wb_state_e;

endpackage

// File: rtl/cache_wb_buffer.sv
// Write-back buffer between cache controller and memory: coalesces line
// writes, forwards buffered data to reads, drains entries in allocation order.
module cache_wb_buffer
  import cache_def_pipe_data::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  mem_req_type  cache_req,
  output mem_data_type cache_rsp,
  output mem_req_type  mem_req,
  input  mem_data_type mem_rsp,
  output logic         full
);

  localparam int unsigned NENT = DEPTH;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] f_idx(input int unsigned v);
    return PW'(v % NENT);
  endfunction

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return f_idx(32'(p) + 1);
  endfunction

  wb_entry_type  r_ent [NENT];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  wb_state_e     r_state;
  wb_state_e     w_state_nxt;
  logic          r_rd_busy;
  logic [31:4]   r_rd_line;
  mem_data_type  r_rsp;
  mem_req_type   r_mem_req;

  logic          w_issue_rd;
  logic          w_issue_wr;
  logic          w_head_busy;
  logic          w_wr_done;
  logic          w_rd_done;
  logic          w_can_take;
  logic          w_free_tail;
  logic          w_acc_wr;
  logic          w_acc_rd;
  logic          w_co_hit;
  logic [PW-1:0] w_co_idx;
  logic          w_rd_hit;
  logic [127:0]  w_rd_data;
  logic [PW-1:0] w_idx;
  logic          w_full;
  logic          w_unused_addr;

  assign w_unused_addr = ^cache_req.addr[3:0];

  always_comb begin
    w_state_nxt = r_state;
    w_issue_rd  = 1'b0;
    w_issue_wr  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_rd_busy) begin
          w_issue_rd  = 1'b1;
          w_state_nxt = RD_WAIT;
        end else if (r_ent[r_head].valid) begin
          w_issue_wr  = 1'b1;
          w_state_nxt = WR_WAIT;
        end
      end
      RD_WAIT: if (mem_rsp.ready) w_state_nxt = IDLE;
      WR_WAIT: if (mem_rsp.ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_wr_done = (r_state == WR_WAIT) && mem_rsp.ready;
  assign w_rd_done = (r_state == RD_WAIT) && mem_rsp.ready;
  // The head is already committed to memory on the edge IDLE issues it,
  // so it must not absorb a coalescing write on that same edge.
  assign w_head_busy = (r_state == WR_WAIT) || w_issue_wr;

  always_comb begin
    w_co_hit  = 1'b0;
    w_co_idx  = '0;
    w_rd_hit  = 1'b0;
    w_rd_data = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NENT; k++) begin
      w_idx = f_idx(32'(r_head) + k);
      if (r_ent[w_idx].valid && (r_ent[w_idx].line_addr == cache_req.addr[31:4])) begin
        w_rd_hit  = 1'b1;
        w_rd_data = r_ent[w_idx].data;
        if (!w_co_hit && !(w_head_busy && (w_idx == r_head))) begin
          w_co_hit = 1'b1;
          w_co_idx = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_full = 1'b1;
    for (int unsigned k = 0; k < NENT; k++) begin
      w_full = w_full & r_ent[k].valid;
    end
  end

  assign full = w_full;

  // When full, tail == head, so a draining head frees the slot being allocated.
  assign w_free_tail = !r_ent[r_tail].valid || (w_wr_done && (r_tail == r_head));
  assign w_can_take  = cache_req.valid && !r_rsp.ready && !r_rd_busy;
  assign w_acc_wr    = w_can_take && cache_req.rw && (w_co_hit || w_free_tail);
  assign w_acc_rd    = w_can_take && !cache_req.rw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NENT; k++) begin
        r_ent[k] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_wr_done) begin
        r_ent[r_head].valid <= 1'b0;
        r_head              <= f_inc(r_head);
      end
      if (w_acc_wr) begin
        if (w_co_hit) begin
          r_ent[w_co_idx].data <= cache_req.data;
        end else begin
          r_ent[r_tail] <= '{valid: 1'b1, line_addr: cache_req.addr[31:4], data: cache_req.data};
          r_tail        <= f_inc(r_tail);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_busy <= 1'b0;
      r_rd_line <= '0;
    end else if (w_rd_done) begin
      r_rd_busy <= 1'b0;
    end else if (w_acc_rd && !w_rd_hit) begin
      r_rd_busy <= 1'b1;
      r_rd_line <= cache_req.addr[31:4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp <= '0;
    end else if (w_rd_done) begin
      r_rsp <= '{data: mem_rsp.data, ready: 1'b1};
    end else if (w_acc_wr) begin
      r_rsp <= '{data: '0, ready: 1'b1};
    end else if (w_acc_rd && w_rd_hit) begin
      r_rsp <= '{data: w_rd_data, ready: 1'b1};
    end else begin
      r_rsp <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_req <= '0;
    end else if (w_issue_rd) begin
      r_mem_req <= '{addr: {r_rd_line, 4'h0}, data: '0, rw: 1'b0, valid: 1'b1};
    end else if (w_issue_wr) begin
      r_mem_req <= '{addr: {r_ent[r_head].line_addr, 4'h0}, data: r_ent[r_head].data,
                     rw: 1'b1, valid: 1'b1};
    end else if (w_rd_done || w_wr_done) begin
      r_mem_req <= '0;
    end
  end

  assign cache_rsp = r_rsp;
  assign mem_req   = r_mem_req;

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Directed self-checking bench for cache_wb_buffer (DEPTH=2); memory
// responses are driven by hand at fixed cycles.
module tb_cache_wb_buffer;
  import cache_def_pipe_data::*;

  logic         clk = 1'b0;
  logic         rst_n;
  mem_req_type  cache_req;
  mem_data_type cache_rsp;
  mem_req_type  mem_req;
  mem_data_type mem_rsp;
  logic         full;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] D1 = 128'h1111_0001_2222_0002_3333_0003_4444_0004;
  localparam logic [127:0] D2 = 128'hD2D2_0000_0000_0000_0000_0000_0000_D2D2;
  localparam logic [127:0] DA = 128'hAAAA_0100_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] DB = 128'hBBBB_0200_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] DC = 128'hCCCC_0300_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] DE = 128'hEEEE_0080_0000_0000_0000_0000_0000_0005;
  localparam logic [127:0] DF = 128'hFFFF_0600_0000_0000_0000_0000_0000_0006;
  localparam logic [127:0] DG = 128'h6060_6060_0000_0000_0000_0000_1234_5678;
  localparam logic [127:0] DM = 128'h4000_4000_DEAD_BEEF_CAFE_F00D_0000_0007;
  localparam logic [127:0] DX = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

  cache_wb_buffer #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cache_req (cache_req),
    .cache_rsp (cache_rsp),
    .mem_req   (mem_req),
    .mem_rsp   (mem_rsp),
    .full      (full)
  );

  always #5 clk = ~clk;

  function automatic mem_req_type mk_req(input logic [31:0] a, input logic [127:0] d,
                                         input logic rw, input logic v);
    return '{addr: a, data: d, rw: rw, valid: v};
  endfunction

  function automatic mem_data_type mk_rsp(input logic [127:0] d, input logic r);
    return '{data: d, ready: r};
  endfunction

  task automatic chk(input string tag, input logic [161:0] obs, input logic [161:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [127:0] d, input logic rw);
    cache_req = mk_req(a, d, rw, 1'b1);
  endtask

  task automatic idle_req();
    cache_req = '0;
  endtask

  task automatic mem_ack(input logic [127:0] d);
    mem_rsp = mk_rsp(d, 1'b1);
    tick();
    mem_rsp = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cache_req = '0;
    mem_rsp   = '0;
    tick();
    tick();
    chk("rst_mem_req", mem_req, '0);
    chk("rst_cache_rsp", cache_rsp, '0);
    chk("rst_full", full, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single write-back: ack, issue, hold, free
    drive(32'h0000_1230, D1, 1'b1);
    tick();
    chk("wr1_rsp", cache_rsp, mk_rsp('0, 1'b1));
    chk("wr1_mem_pre", mem_req, '0);
    idle_req();
    tick();
    chk("wr1_issue", mem_req, mk_req(32'h0000_1230, D1, 1'b1, 1'b1));
    chk("wr1_rsp_drop", cache_rsp, '0);
    tick();
    chk("wr1_hold", mem_req, mk_req(32'h0000_1230, D1, 1'b1, 1'b1));
    mem_ack('0);
    chk("wr1_mem_clr", mem_req, '0);
    chk("wr1_full", full, 1'b0);
    mem_rsp = mk_rsp(DX, 1'b1);
    tick();
    mem_rsp = '0;
    chk("idle_ack_rsp", cache_rsp, '0);
    chk("idle_ack_mem", mem_req, '0);

    // Read hit on a line being drained
    drive(32'h0000_2000, D2, 1'b1);
    tick();
    chk("raw_wr_rsp", cache_rsp, mk_rsp('0, 1'b1));
    idle_req();
    tick();
    chk("raw_wr_issue", mem_req, mk_req(32'h0000_2000, D2, 1'b1, 1'b1));
    drive(32'h0000_2008, '0, 1'b0);
    tick();
    chk("raw_hit_rsp", cache_rsp, mk_rsp(D2, 1'b1));
    idle_req();
    chk("raw_mem_unchanged", mem_req, mk_req(32'h0000_2000, D2, 1'b1, 1'b1));
    mem_ack('0);
    tick();
    chk("raw_no_mem_rd", mem_req, '0);

    // Full buffer: third write waits until the head drains
    drive(32'h0000_0100, DA, 1'b1);
    tick();
    chk("full_w1_rsp", cache_rsp, mk_rsp('0, 1'b1));
    idle_req();
    tick();
    chk("full_w1_issue", mem_req, mk_req(32'h0000_0100, DA, 1'b1, 1'b1));
    drive(32'h0000_0200, DB, 1'b1);
    tick();
    chk("full_w2_rsp", cache_rsp, mk_rsp('0, 1'b1));
    idle_req();
    tick();
    chk("full_set", full, 1'b1);
    drive(32'h0000_0300, DC, 1'b1);
    tick();
    chk("full_wait1", cache_rsp, '0);
    tick();
    chk("full_wait2", cache_rsp, '0);
    mem_rsp = mk_rsp('0, 1'b1);
    tick();
    mem_rsp = '0;
    idle_req();
    chk("full_accept_rsp", cache_rsp, mk_rsp('0, 1'b1));
    chk("full_still", full, 1'b1);
    chk("full_mem_clr", mem_req, '0);
    tick();
    chk("full_drain2", mem_req, mk_req(32'h0000_0200, DB, 1'b1, 1'b1));
    chk("full_rsp_pulse", cache_rsp, '0);
    mem_ack('0);
    tick();
    chk("full_drain3", mem_req, mk_req(32'h0000_0300, DC, 1'b1, 1'b1));
    mem_ack('0);
    chk("full_empty", full, 1'b0);

    // Read miss takes priority over a buffered write
    drive(32'h0000_0080, DE, 1'b1);
    tick();
    idle_req();
    tick();
    chk("pri_w0_issue", mem_req, mk_req(32'h0000_0080, DE, 1'b1, 1'b1));
    drive(32'h0000_0100, DA, 1'b1);
    tick();
    chk("pri_w1_rsp", cache_rsp, mk_rsp('0, 1'b1));
    idle_req();
    tick();
    drive(32'h0000_4000, '0, 1'b0);
    tick();
    idle_req();
    chk("pri_miss_norsp", cache_rsp, '0);
    mem_ack('0);
    tick();
    chk("pri_rd_issue", mem_req, mk_req(32'h0000_4000, '0, 1'b0, 1'b1));
    mem_rsp = mk_rsp(DM, 1'b1);
    tick();
    mem_rsp = '0;
    chk("pri_rd_data", cache_rsp, mk_rsp(DM, 1'b1));
    chk("pri_rd_mem_clr", mem_req, '0);
    tick();
    chk("pri_wr_after", mem_req, mk_req(32'h0000_0100, DA, 1'b1, 1'b1));
    chk("pri_rsp_drop", cache_rsp, '0);
    mem_ack('0);
    chk("pri_full", full, 1'b0);

    // Coalesce two writes to one line behind an in-flight write
    drive(32'h0000_0080, DE, 1'b1);
    tick();
    idle_req();
    tick();
    drive(32'h0000_0500, DA, 1'b1);
    tick();
    idle_req();
    tick();
    drive(32'h0000_0500, DB, 1'b1);
    tick();
    chk("coal_rsp", cache_rsp, mk_rsp('0, 1'b1));
    idle_req();
    chk("coal_full", full, 1'b1);
    mem_ack('0);
    chk("coal_one_entry", full, 1'b0);
    tick();
    chk("coal_issue", mem_req, mk_req(32'h0000_0500, DB, 1'b1, 1'b1));
    mem_ack('0);
    tick();
    chk("coal_single_wr", mem_req, '0);
    chk("coal_empty", full, 1'b0);

    // Reset during WR_WAIT abandons the write
    drive(32'h0000_0604, DF, 1'b1);
    tick();
    idle_req();
    tick();
    chk("rstw_issue_aligned", mem_req, mk_req(32'h0000_0600, DF, 1'b1, 1'b1));
    rst_n = 1'b0;
    tick();
    chk("rstw_mem_req", mem_req, '0);
    chk("rstw_cache_rsp", cache_rsp, '0);
    chk("rstw_full", full, 1'b0);
    rst_n = 1'b1;
    tick();
    drive(32'h0000_0600, '0, 1'b0);
    tick();
    idle_req();
    chk("rstw_rd_miss", cache_rsp, '0);
    tick();
    chk("rstw_rd_issue", mem_req, mk_req(32'h0000_0600, '0, 1'b0, 1'b1));
    mem_rsp = mk_rsp(DG, 1'b1);
    tick();
    mem_rsp = '0;
    chk("rstw_rd_data", cache_rsp, mk_rsp(DG, 1'b1));
    tick();
    chk("rstw_rsp_single", cache_rsp, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
